// File: rtl/my_uart_rx.sv
// my_uart_rx: receiver for the 23-slot two-channel AD sample frame.
// Ports: clk_1M (bit clock), rst (async, active low), rs232_rx (serial in, idles high),
//        Arx_data/Brx_data (last good frame bytes), rx_valid (1-cycle new-data pulse),
//        frame_err (1-cycle bad-frame pulse).
// Optional macro MY_UART_RX_CHECK_EN enables the fixed-slot checks, frame_err and ERR_WAIT.
module my_uart_rx (
    input  logic       clk_1M,
    input  logic       rst,
    input  logic       rs232_rx,
    output logic [7:0] Arx_data,
    output logic [7:0] Brx_data,
    output logic       rx_valid,
    output logic       frame_err
);

`ifdef MY_UART_RX_CHECK_EN
    typedef enum logic [1:0] {IDLE, RECV, DONE, ERR_WAIT} state_t;
`else
    typedef enum logic [1:0] {IDLE, RECV, DONE} state_t;
`endif

    state_t     state, state_nx;
    logic [4:0] idx, idx_nx;
    logic       sync1, rx_s;
    logic       armed;
    logic       arm_clr;
    logic       valid_nx;
    logic [7:0] a_sh, b_sh;

`ifdef MY_UART_RX_CHECK_EN
    logic       err_nx;
    logic       sticky;
    logic       stop_hi;
    logic       chk_slot;

    assign chk_slot = (idx == 5'd10) || (idx == 5'd11) ||
                      (idx == 5'd20) || (idx == 5'd21);
`else
    assign frame_err = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        valid_nx = 1'b0;
`ifdef MY_UART_RX_CHECK_EN
        err_nx   = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (armed && !rx_s) begin
                    state_nx = RECV;
                    idx_nx   = 5'd1;
                end
            end
            RECV: begin
                idx_nx = idx + 5'd1;
                if (idx == 5'd1 && rx_s) begin
                    state_nx = IDLE;
                end else if (idx == 5'd22) begin
                    state_nx = DONE;
`ifdef MY_UART_RX_CHECK_EN
                    // Stop slot is checked live; the sticky bit holds the rest.
                    if (sticky || !rx_s) err_nx = 1'b1;
                    else                 valid_nx = 1'b1;
`else
                    valid_nx = 1'b1;
`endif
                end
            end
            DONE: begin
                state_nx = IDLE;
`ifdef MY_UART_RX_CHECK_EN
                // A low stop slot means the line may be stuck low.
                if (frame_err && !stop_hi) state_nx = ERR_WAIT;
`endif
            end
`ifdef MY_UART_RX_CHECK_EN
            ERR_WAIT: begin
                if (rx_s) state_nx = IDLE;
            end
`endif
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        arm_clr = (state_nx == RECV) && (state != RECV);
`ifdef MY_UART_RX_CHECK_EN
        if ((state_nx == ERR_WAIT) && (state != ERR_WAIT)) arm_clr = 1'b1;
`endif
    end

    always_ff @(posedge clk_1M or negedge rst) begin
        if (!rst) begin
            sync1    <= 1'b1;
            rx_s     <= 1'b1;
            state    <= IDLE;
            idx      <= 5'd0;
            armed    <= 1'b0;
            a_sh     <= 8'h00;
            b_sh     <= 8'h00;
            Arx_data <= 8'h00;
            Brx_data <= 8'h00;
            rx_valid <= 1'b0;
        end else begin
            sync1    <= rs232_rx;
            rx_s     <= sync1;
            state    <= state_nx;
            idx      <= idx_nx;
            rx_valid <= valid_nx;
            if (arm_clr)   armed <= 1'b0;
            else if (rx_s) armed <= 1'b1;
            if (state == RECV) begin
                if (idx >= 5'd2 && idx <= 5'd9)
                    a_sh <= {rx_s, a_sh[7:1]};
                if (idx >= 5'd12 && idx <= 5'd19)
                    b_sh <= {rx_s, b_sh[7:1]};
            end
            if (valid_nx) begin
                Arx_data <= a_sh;
                Brx_data <= b_sh;
            end
        end
    end

`ifdef MY_UART_RX_CHECK_EN
    always_ff @(posedge clk_1M or negedge rst) begin
        if (!rst) begin
            frame_err <= 1'b0;
            sticky    <= 1'b0;
            stop_hi   <= 1'b0;
        end else begin
            frame_err <= err_nx;
            if (state_nx == RECV && state != RECV)
                sticky <= 1'b0;
            else if (state == RECV && chk_slot && rx_s)
                sticky <= 1'b1;
            if (state == RECV && idx == 5'd22)
                stop_hi <= rx_s;
        end
    end
`endif

endmodule
